fleet_placement_ctrl: RTL

FLEET_PLACEMENT_CTRL -- requirements
Module: fleet_placement_ctrl

---
 rtl/fleet_placement_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/fleet_placement_ctrl.sv
// Fleet placement controller: two players take turns placing NUM_SHIPS ships
// on a GRID_W x GRID_H grid using debounced buttons. Ship i has length
// SHIP_LEN_MAX-i. The cursor anchor is the ship's top-left cell, and the
// footprint always stays inside the grid.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start; buttons ignored, cursor_mask zero
// P1_PLACE | player 1 positions and places ships into placed_p1
// P2_PLACE | player 2 positions and places ships into placed_p2
// DONE     | both fleets committed; grids hold, buttons ignored
module fleet_placement_ctrl #(
    parameter int GRID_W       = 6,
    parameter int GRID_H       = 6,
    parameter int NUM_SHIPS    = 3,
    parameter int SHIP_LEN_MAX = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               up,
    input  logic                               down,
    input  logic                               left,
    input  logic                               right,
    input  logic                               rotate,
    input  logic                               place,
    input  logic                               start,
    output logic [GRID_W*GRID_H-1:0]           cursor_mask,
    output logic [GRID_W*GRID_H-1:0]           placed_p1,
    output logic [GRID_W*GRID_H-1:0]           placed_p2,
    output logic                               active_player,
    output logic [$clog2(NUM_SHIPS+1)-1:0]     ship_idx,
    output logic                               vertical,
    output logic                               place_ok,
    output logic                               place_err,
    output logic                               p1_complete,
    output logic                               p2_complete,
    output logic                               all_complete
);

    localparam int N  = GRID_W * GRID_H;
    localparam int IW = $clog2(NUM_SHIPS + 1);
    localparam int CW = 5;

    typedef enum logic [1:0] {IDLE, P1_PLACE, P2_PLACE, DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cur_x, cur_y, cur_x_nx, cur_y_nx;
    logic            vert_nx;
    logic [IW-1:0]   idx_nx;
    logic [N-1:0]    p1_nx, p2_nx;
    logic            p1c_nx, p2c_nx, allc_nx, err_nx;
    logic [5:0]      btn, btn_prev, rise;
    logic [N-1:0]    footprint, active_grid;
    logic            in_place;
    int              ship_len;

    // Button order: up, down, left, right, rotate, place
    assign btn  = {up, down, left, right, rotate, place};
    assign rise = btn & ~btn_prev;

    // True when a ship of length l anchored at (x,y) lies fully inside the grid
    function automatic logic fits(input int x, input int y, input int l, input logic v);
        if (x < 0 || y < 0) return 1'b0;
        if (v) return (x < GRID_W) && (y + l <= GRID_H);
        return (y < GRID_H) && (x + l <= GRID_W);
    endfunction

    // Footprint of the current ship at the cursor
    always_comb begin
        footprint = '0;
        ship_len  = SHIP_LEN_MAX - int'(ship_idx);
        for (int yy = 0; yy < GRID_H; yy++) begin
            for (int xx = 0; xx < GRID_W; xx++) begin
                if (vertical)
                    footprint[yy*GRID_W+xx] = (xx == int'(cur_x)) && (yy >= int'(cur_y))
                                              && (yy < int'(cur_y) + ship_len);
                else
                    footprint[yy*GRID_W+xx] = (yy == int'(cur_y)) && (xx >= int'(cur_x))
                                              && (xx < int'(cur_x) + ship_len);
            end
        end
    end

    assign in_place      = (state == P1_PLACE) || (state == P2_PLACE);
    assign active_grid   = (state == P2_PLACE) ? placed_p2 : placed_p1;
    assign place_ok      = ~|(footprint & active_grid);
    assign cursor_mask   = in_place ? footprint : '0;
    assign active_player = (state == P2_PLACE) || (state == DONE);

    // Next-state and datapath update; place beats rotate beats moves
    always_comb begin
        state_nx = state;
        cur_x_nx = cur_x;
        cur_y_nx = cur_y;
        vert_nx  = vertical;
        idx_nx   = ship_idx;
        p1_nx    = placed_p1;
        p2_nx    = placed_p2;
        p1c_nx   = p1_complete;
        p2c_nx   = p2_complete;
        allc_nx  = all_complete;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = P1_PLACE;
                    cur_x_nx = '0;
                    cur_y_nx = '0;
                    vert_nx  = 1'b0;
                    idx_nx   = '0;
                end
            end
            P1_PLACE, P2_PLACE: begin
                if (rise[0]) begin
                    if (place_ok) begin
                        if (state == P1_PLACE) p1_nx = placed_p1 | footprint;
                        else                   p2_nx = placed_p2 | footprint;
                        cur_x_nx = '0;
                        cur_y_nx = '0;
                        vert_nx  = 1'b0;
                        if (int'(ship_idx) == NUM_SHIPS - 1) begin
                            idx_nx = '0;
                            if (state == P1_PLACE) begin
                                p1c_nx   = 1'b1;
                                state_nx = P2_PLACE;
                            end else begin
                                p2c_nx   = 1'b1;
                                allc_nx  = 1'b1;
                                state_nx = DONE;
                            end
                        end else begin
                            idx_nx = ship_idx + 1'b1;
                        end
                    end else begin
                        err_nx = 1'b1;
                    end
                end else if (rise[1]) begin
                    if (fits(int'(cur_x), int'(cur_y), ship_len, ~vertical))
                        vert_nx = ~vertical;
                end else begin
                    if (rise[2] && !rise[3]) begin
                        if (fits(int'(cur_x) + 1, int'(cur_y), ship_len, vertical))
                            cur_x_nx = cur_x + 1'b1;
                    end else if (rise[3] && !rise[2]) begin
                        if (fits(int'(cur_x) - 1, int'(cur_y), ship_len, vertical))
                            cur_x_nx = cur_x - 1'b1;
                    end
                    if (rise[4] && !rise[5]) begin
                        if (fits(int'(cur_x), int'(cur_y) + 1, ship_len, vertical))
                            cur_y_nx = cur_y + 1'b1;
                    end else if (rise[5] && !rise[4]) begin
                        if (fits(int'(cur_x), int'(cur_y) - 1, ship_len, vertical))
                            cur_y_nx = cur_y - 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State register with asynchronous reset clearing everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cur_x        <= '0;
            cur_y        <= '0;
            vertical     <= 1'b0;
            ship_idx     <= '0;
            placed_p1    <= '0;
            placed_p2    <= '0;
            p1_complete  <= 1'b0;
            p2_complete  <= 1'b0;
            all_complete <= 1'b0;
            place_err    <= 1'b0;
            btn_prev     <= '0;
        end else begin
            state        <= state_nx;
            cur_x        <= cur_x_nx;
            cur_y        <= cur_y_nx;
            vertical     <= vert_nx;
            ship_idx     <= idx_nx;
            placed_p1    <= p1_nx;
            placed_p2    <= p2_nx;
            p1_complete  <= p1c_nx;
            p2_complete  <= p2c_nx;
            all_complete <= allc_nx;
            place_err    <= err_nx;
            btn_prev     <= btn;
        end
    end

endmodule
